// File: rtl/dc_ctrl.sv
// Direct-mapped cache controller: tag lookup, dirty-victim writeback,
// line fill and tag update, with saturating hit/miss/writeback counters.
module dc_ctrl #(
  parameter int TAG_W = 6,
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid,
  input  logic               req_wr,
  input  logic [TAG_W+8:0]   req_addr,
  output logic               req_ready,
  output logic               resp_valid,
  output logic               resp_hit,
  output logic [4:0]         ts_index,
  output logic               ts_wr_n,
  output logic [TAG_W+1:0]   ts_wdata,
  input  logic [TAG_W+1:0]   ts_rdata,
  output logic               mem_req,
  output logic               mem_wr,
  output logic [TAG_W+4:0]   mem_addr,
  input  logic               mem_ack,
  output logic               fill_we,
  output logic [CNT_W-1:0]   hit_cnt,
  output logic [CNT_W-1:0]   miss_cnt,
  output logic [CNT_W-1:0]   wb_cnt
);

  typedef enum logic [2:0] {IDLE, LOOKUP, WB, FILL, UPDATE} state_t;

  state_t           state;
  logic             lat_wr;
  logic [TAG_W-1:0] lat_tag;
  logic [4:0]       lat_index;
  logic [TAG_W-1:0] victim_tag;

  logic             rd_valid;
  logic             rd_dirty;
  logic             lookup_hit;

  // The byte offset selects a word inside the line and never reaches the controller.
  logic             unused_offset;
  assign unused_offset = ^req_addr[3:0];

  assign rd_valid   = ts_rdata[TAG_W+1];
  assign rd_dirty   = ts_rdata[TAG_W];
  assign lookup_hit = rd_valid && (ts_rdata[TAG_W-1:0] == lat_tag);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // State, latched request, victim tag and statistics advance on each rising edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      lat_wr     <= 1'b0;
      lat_tag    <= '0;
      lat_index  <= '0;
      victim_tag <= '0;
      hit_cnt    <= '0;
      miss_cnt   <= '0;
      wb_cnt     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            lat_wr    <= req_wr;
            lat_tag   <= req_addr[TAG_W+8:9];
            lat_index <= req_addr[8:4];
            state     <= LOOKUP;
          end
        end
        LOOKUP: begin
          if (lookup_hit) begin
            hit_cnt <= sat_inc(hit_cnt);
            state   <= IDLE;
          end else begin
            miss_cnt   <= sat_inc(miss_cnt);
            victim_tag <= ts_rdata[TAG_W-1:0];
            state      <= (rd_valid && rd_dirty) ? WB : FILL;
          end
        end
        WB: begin
          if (mem_ack) begin
            wb_cnt <= sat_inc(wb_cnt);
            state  <= FILL;
          end
        end
        FILL: begin
          if (mem_ack) state <= UPDATE;
        end
        UPDATE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Outputs decode the state; lookup results and the fill strobe follow same-cycle inputs.
  always_comb begin
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    resp_hit   = 1'b0;
    ts_index   = lat_index;
    ts_wr_n    = 1'b1;
    ts_wdata   = '0;
    mem_req    = 1'b0;
    mem_wr     = 1'b0;
    mem_addr   = '0;
    fill_we    = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        ts_index  = req_addr[8:4];
      end
      LOOKUP: begin
        if (lookup_hit) begin
          resp_valid = 1'b1;
          resp_hit   = 1'b1;
          if (lat_wr && !rd_dirty) begin
            ts_wr_n  = 1'b0;
            ts_wdata = {2'b11, lat_tag};
          end
        end
      end
      WB: begin
        mem_req  = 1'b1;
        mem_wr   = 1'b1;
        mem_addr = {victim_tag, lat_index};
      end
      FILL: begin
        mem_req  = 1'b1;
        mem_addr = {lat_tag, lat_index};
        fill_we  = mem_ack;
      end
      UPDATE: begin
        ts_wr_n    = 1'b0;
        ts_wdata   = {1'b1, lat_wr, lat_tag};
        resp_valid = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_dc_ctrl.sv
// Self-checking bench for dc_ctrl: directed transactions, response scoreboard,
// counter model with saturation (counters built 2 bits wide).
module tb_dc_ctrl;

  localparam int CW     = 2;
  localparam int CNTMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid;
  logic          req_wr;
  logic [14:0]   req_addr;
  logic          req_ready;
  logic          resp_valid;
  logic          resp_hit;
  logic [4:0]    ts_index;
  logic          ts_wr_n;
  logic [7:0]    ts_wdata;
  logic [7:0]    ts_rdata;
  logic          mem_req;
  logic          mem_wr;
  logic [10:0]   mem_addr;
  logic          mem_ack;
  logic          fill_we;
  logic [CW-1:0] hit_cnt;
  logic [CW-1:0] miss_cnt;
  logic [CW-1:0] wb_cnt;

  int checks = 0;
  int passes = 0;
  bit exp_hit_q[$];
  int exp_hits = 0;
  int exp_misses = 0;
  int exp_wbs = 0;

  dc_ctrl #(.TAG_W(6), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_wr(req_wr),
    .req_addr(req_addr), .req_ready(req_ready), .resp_valid(resp_valid),
    .resp_hit(resp_hit), .ts_index(ts_index), .ts_wr_n(ts_wr_n),
    .ts_wdata(ts_wdata), .ts_rdata(ts_rdata), .mem_req(mem_req),
    .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_ack(mem_ack),
    .fill_we(fill_we), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt), .wb_cnt(wb_cnt)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual === expected) passes++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
  endtask

  function automatic int satInc(input int v);
    return (v >= CNTMAX) ? CNTMAX : v + 1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every response pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin : resp_monitor
    bit e;
    if (resp_valid === 1'b1) begin
      if (exp_hit_q.size() == 0) checkOutput("resp_unexpected", 1, 0);
      else begin
        e = exp_hit_q.pop_front();
        checkOutput("resp_hit", resp_hit, e);
      end
    end
  end

  task automatic checkIdleOutputs(input string tag);
    checkOutput({tag, "_ready"}, req_ready, 1);
    checkOutput({tag, "_mem_req"}, mem_req, 0);
    checkOutput({tag, "_mem_wr"}, mem_wr, 0);
    checkOutput({tag, "_mem_addr"}, mem_addr, 0);
    checkOutput({tag, "_fill_we"}, fill_we, 0);
    checkOutput({tag, "_ts_wr_n"}, ts_wr_n, 1);
    checkOutput({tag, "_ts_wdata"}, ts_wdata, 0);
    checkOutput({tag, "_resp_valid"}, resp_valid, 0);
    checkOutput({tag, "_resp_hit"}, resp_hit, 0);
  endtask

  task automatic checkCounters(input string tag);
    checkOutput({tag, "_hit_cnt"}, hit_cnt, exp_hits);
    checkOutput({tag, "_miss_cnt"}, miss_cnt, exp_misses);
    checkOutput({tag, "_wb_cnt"}, wb_cnt, exp_wbs);
  endtask

  // One request from IDLE through completion; entered and left at posedge+1 in IDLE.
  task automatic applyStimulus(input logic wr, input logic [14:0] addr,
                               input logic [7:0] rd, input bit abort_in_fill);
    logic [5:0] tag;
    logic [4:0] idx;
    bit         hit;
    bit         dirty_victim;
    tag = addr[14:9];
    idx = addr[8:4];
    hit = rd[7] && (rd[5:0] == tag);
    dirty_victim = rd[7] && rd[6];

    req_valid = 1'b1; req_wr = wr; req_addr = addr; mem_ack = 1'b0;
    @(negedge clk);
    checkOutput("idle_ready", req_ready, 1);
    checkOutput("idle_index", ts_index, idx);
    if (hit || !abort_in_fill) exp_hit_q.push_back(hit);
    tick();

    // LOOKUP: a competing request and a stray ack must both be ignored.
    req_addr = ~addr; req_wr = ~wr; ts_rdata = rd; mem_ack = 1'b1;
    @(negedge clk);
    checkOutput("lookup_ready", req_ready, 0);
    checkOutput("lookup_index", ts_index, idx);
    checkOutput("lookup_mem_req", mem_req, 0);
    if (hit) begin
      checkOutput("lookup_ts_wr_n", ts_wr_n, !(wr && !rd[6]));
      if (wr && !rd[6]) checkOutput("lookup_ts_wdata", ts_wdata, {2'b11, tag});
      exp_hits = satInc(exp_hits);
      tick();
      req_valid = 1'b0; mem_ack = 1'b0;
    end else begin
      checkOutput("lookup_miss_ts_wr_n", ts_wr_n, 1);
      exp_misses = satInc(exp_misses);
      tick();
      mem_ack = 1'b0;
      if (dirty_victim) begin
        for (int i = 0; i < 2; i++) begin
          @(negedge clk);
          checkOutput("wb_mem_req", mem_req, 1);
          checkOutput("wb_mem_wr", mem_wr, 1);
          checkOutput("wb_mem_addr", mem_addr, {rd[5:0], idx});
          checkOutput("wb_ts_wr_n", ts_wr_n, 1);
          tick();
        end
        mem_ack = 1'b1;
        @(negedge clk);
        checkOutput("wb_ack_fill_we", fill_we, 0);
        exp_wbs = satInc(exp_wbs);
        tick();
        mem_ack = 1'b0;
      end
      @(negedge clk);
      checkOutput("fill_mem_req", mem_req, 1);
      checkOutput("fill_mem_wr", mem_wr, 0);
      checkOutput("fill_mem_addr", mem_addr, {tag, idx});
      checkOutput("fill_we_idle", fill_we, 0);
      if (abort_in_fill) begin
        tick();
        rst = 1'b1; req_valid = 1'b0;
        tick();
        exp_hits = 0; exp_misses = 0; exp_wbs = 0;
        @(negedge clk);
        checkIdleOutputs("abort");
        checkCounters("abort");
        rst = 1'b0;
        tick();
        return;
      end
      tick();
      mem_ack = 1'b1;
      @(negedge clk);
      checkOutput("fill_we_pulse", fill_we, 1);
      tick();
      mem_ack = 1'b0; req_valid = 1'b0;
      @(negedge clk);
      checkOutput("update_ts_wr_n", ts_wr_n, 0);
      checkOutput("update_ts_wdata", ts_wdata, {1'b1, wr, tag});
      checkOutput("update_mem_req", mem_req, 0);
      checkOutput("update_fill_we", fill_we, 0);
      tick();
    end
    @(negedge clk);
    checkOutput("done_ready", req_ready, 1);
    checkCounters("done");
    tick();
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_wr = 1'b0; req_addr = '0;
    ts_rdata = '0; mem_ack = 1'b0;
    tick();
    tick();
    @(negedge clk);
    checkIdleOutputs("reset");
    checkCounters("reset");
    rst = 1'b0;
    tick();

    applyStimulus(1'b0, 15'h0A35, 8'h85, 1'b0);  // load hit, clean line
    applyStimulus(1'b1, 15'h0A35, 8'h85, 1'b0);  // store hit on clean line: dirty write
    applyStimulus(1'b1, 15'h0A35, 8'hC5, 1'b0);  // store hit on dirty line: no write
    applyStimulus(1'b0, 15'h0A35, 8'hC7, 1'b0);  // load miss, dirty victim tag 7
    applyStimulus(1'b1, 15'h0A35, 8'h00, 1'b0);  // store miss, empty line
    applyStimulus(1'b0, 15'h0A35, 8'h87, 1'b0);  // load miss, clean victim
    applyStimulus(1'b0, 15'h0A35, 8'h45, 1'b0);  // matching tag but invalid
    applyStimulus(1'b0, 15'h7FF0, 8'hBF, 1'b0);  // top tag/index hit
    applyStimulus(1'b1, 15'h1234, 8'h00, 1'b1);  // reset while filling
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 15'h0A35, 8'h85, 1'b0);
    checkOutput("sat_hit_cnt", hit_cnt, CNTMAX);

    checkOutput("scoreboard_empty", exp_hit_q.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
